ds18b20_sequencer: RTL and testbench



---
 rtl/ds18b20_pkg.sv | 45 ++++
 rtl/ds18b20_sequencer_if.sv | 20 ++
 rtl/ds_crc8.sv | 31 +++
 rtl/ds18b20_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_ds18b20_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ds18b20_pkg.sv
// Shared constants, state encodings and error codes for the DS18B20 conversion sequencer.
package ds18b20_pkg;

    localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T = 8'h44;
    localparam logic [7:0] CMD_READ_SP   = 8'hBE;
    localparam int         SP_BYTES      = 9;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NOPRES  = 2'd1,
        ERR_CRC     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST1,
        ST_SKIP1,
        ST_CONV,
        ST_WAITC,
        ST_RST2,
        ST_SKIP2,
        ST_RDCMD,
        ST_RD,
        ST_CHECK
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_ISSUE,
        OP_ACK,
        OP_WAIT
    } op_state_e;

    // Command byte presented to one_wire while a write op is in flight.
    function automatic logic [7:0] cmd_for_state(input seq_state_e s);
        case (s)
            ST_SKIP1, ST_SKIP2: return CMD_SKIP_ROM;
            ST_CONV:            return CMD_CONVERT_T;
            ST_RDCMD:           return CMD_READ_SP;
            default:            return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ds18b20_sequencer_if.sv
// Strobe/byte interface between the sequencer and the one_wire byte master.
interface ds18b20_sequencer_if;
    logic       ow_reset;
    logic       ow_write_byte;
    logic       ow_read_byte;
    logic [7:0] ow_in_byte;
    logic       ow_busy;
    logic       ow_presense;
    logic [7:0] ow_out_byte;

    modport master (
        output ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
        input  ow_busy, ow_presense, ow_out_byte
    );

    modport slave (
        input  ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
        output ow_busy, ow_presense, ow_out_byte
    );
endinterface

// File: rtl/ds_crc8.sv
// Byte-wide Dallas/Maxim CRC-8 (reflected poly 0x8C, init 0x00), one byte per enabled cycle.
module ds_crc8 (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        end
        return r;
    endfunction

    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= crc8_byte(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ds18b20_sequencer.sv
// Autonomous DS18B20 transaction sequencer: reset/skip/convert, wait, reset/skip/read scratchpad, CRC check.
module ds18b20_sequencer
    import ds18b20_pkg::*;
#(
    parameter int unsigned CONV_WAIT_CYCLES = 37_500_000,
    parameter int unsigned ACK_TIMEOUT      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    ds18b20_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       present,
    output logic [15:0]                temp,
    output logic                       temp_valid,
    output logic                       done,
    output logic [1:0]                 err
);

    localparam int              AW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0]   ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]      RD_LAST  = 4'(SP_BYTES - 1);

    seq_state_e    state_q, state_d;
    op_state_e     op_q, op_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic [31:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic          present_q, present_d;
    logic [15:0]   temp_q, temp_d;
    logic          temp_valid_q, temp_valid_d;
    logic          done_q, done_d;
    err_e          err_q, err_d;
    logic [7:0]    sp_lo_q, sp_lo_d, sp_hi_q, sp_hi_d;

    logic       is_op, is_rst, is_rd, fire, op_done, abort;
    logic       crc_clr, crc_en;
    logic [7:0] crc;

    ds_crc8 u_crc (
        .clk   (clk),
        .clear (crc_clr),
        .en    (crc_en),
        .din   (bus.ow_out_byte),
        .crc   (crc)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ack_cnt_d    = ack_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        rd_idx_d     = rd_idx_q;
        present_d    = present_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        sp_lo_d      = sp_lo_q;
        sp_hi_d      = sp_hi_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        fire         = 1'b0;
        op_done      = 1'b0;
        abort        = 1'b0;

        is_op  = (state_q inside {ST_RST1, ST_SKIP1, ST_CONV, ST_RST2, ST_SKIP2, ST_RDCMD, ST_RD});
        is_rst = (state_q inside {ST_RST1, ST_RST2});
        is_rd  = (state_q == ST_RD);

        // Shared ISSUE -> ACK -> WAIT handshake for every bus operation.
        if (is_op) begin
            case (op_q)
                OP_ISSUE: begin
                    if (!bus.ow_busy) begin
                        fire      = 1'b1;
                        op_d      = OP_ACK;
                        ack_cnt_d = AW'(1);
                        if (is_rst) present_d = 1'b0;
                        if (state_q == ST_RDCMD) crc_clr = 1'b1;
                    end
                end
                OP_ACK: begin
                    if (is_rst && bus.ow_presense) present_d = 1'b1;
                    if (bus.ow_busy) begin
                        op_d = OP_WAIT;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        err_d = ERR_TIMEOUT;
                        abort = 1'b1;
                    end else begin
                        ack_cnt_d = ack_cnt_q + AW'(1);
                    end
                end
                OP_WAIT: begin
                    if (is_rst && bus.ow_presense) present_d = 1'b1;
                    if (!bus.ow_busy) begin
                        op_d    = OP_ISSUE;
                        op_done = 1'b1;
                    end
                end
                default: op_d = OP_ISSUE;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RST1;
                    op_d    = OP_ISSUE;
                    err_d   = ERR_OK;
                end
            end
            ST_RST1, ST_RST2: begin
                if (op_done) begin
                    if (!present_d) begin
                        err_d = ERR_NOPRES;
                        abort = 1'b1;
                    end else begin
                        state_d = (state_q == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
                    end
                end
            end
            ST_SKIP1: if (op_done) state_d = ST_CONV;
            ST_CONV: begin
                if (op_done) begin
                    state_d    = ST_WAITC;
                    wait_cnt_d = CONV_WAIT_CYCLES;
                end
            end
            ST_WAITC: begin
                if (wait_cnt_q == 32'd1) state_d = ST_RST2;
                else                     wait_cnt_d = wait_cnt_q - 32'd1;
            end
            ST_SKIP2: if (op_done) state_d = ST_RDCMD;
            ST_RDCMD: begin
                if (op_done) begin
                    state_d  = ST_RD;
                    rd_idx_d = 4'd0;
                end
            end
            ST_RD: begin
                if (op_done) begin
                    crc_en = 1'b1;
                    if (rd_idx_q == 4'd0) sp_lo_d = bus.ow_out_byte;
                    if (rd_idx_q == 4'd1) sp_hi_d = bus.ow_out_byte;
                    if (rd_idx_q == RD_LAST) state_d = ST_CHECK;
                    else                     rd_idx_d = rd_idx_q + 4'd1;
                end
            end
            ST_CHECK: begin
                // Running CRC over a good scratchpad including its own CRC byte is zero.
                if (crc == 8'h00) begin
                    temp_d       = {sp_hi_q, sp_lo_q};
                    temp_valid_d = 1'b1;
                    err_d        = ERR_OK;
                end else begin
                    err_d = ERR_CRC;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            op_d    = OP_ISSUE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ISSUE;
            ack_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            rd_idx_q     <= '0;
            present_q    <= 1'b0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ERR_OK;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            ack_cnt_q    <= ack_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_idx_q     <= rd_idx_d;
            present_q    <= present_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        sp_lo_q <= sp_lo_d;
        sp_hi_q <= sp_hi_d;
    end

    assign bus.ow_reset      = fire && is_rst;
    assign bus.ow_write_byte = fire && !is_rst && !is_rd;
    assign bus.ow_read_byte  = fire && is_rd;
    assign bus.ow_in_byte    = cmd_for_state(state_q);

    assign busy       = (state_q != ST_IDLE);
    assign present    = present_q;
    assign temp       = temp_q;
    assign temp_valid = temp_valid_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// Directed bench for ds18b20_sequencer with a behavioural one_wire responder.
module tb_ds18b20_sequencer;

    localparam int ACK_TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, present, temp_valid, done;
    logic [15:0] temp;
    logic [1:0]  err;

    ds18b20_sequencer_if bus ();

    ds18b20_sequencer #(
        .CONV_WAIT_CYCLES (10),
        .ACK_TIMEOUT      (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .present    (present),
        .temp       (temp),
        .temp_valid (temp_valid),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    logic [7:0] sp_img [9];
    logic [7:0] wr_log [64];
    int  n_wr = 0, n_rd = 0, n_rst = 0, n_done = 0, n_tv = 0, n_multi = 0;
    int  cyc_conv = 0, cyc_done = 0;
    bit  pres_en, ignore_en;
    logic [7:0] ignore_cmd;
    bit  ow_act = 0, ow_is_rst = 0, ow_is_rd = 0, model_init = 0;
    int  ow_t = 0, rd_ptr = 0;

    // Monitor then responder: busy rises 2 cycles after a strobe and stays high 20 cycles.
    always @(negedge clk) begin
        if (done === 1'b1) begin n_done++; cyc_done = cyc; end
        if (temp_valid === 1'b1) n_tv++;
        if (int'(bus.ow_reset) + int'(bus.ow_write_byte) + int'(bus.ow_read_byte) > 1) n_multi++;
        if (bus.ow_reset === 1'b1) n_rst++;
        if (bus.ow_read_byte === 1'b1) n_rd++;
        if (bus.ow_write_byte === 1'b1) begin
            if (n_wr < 64) wr_log[n_wr] = bus.ow_in_byte;
            n_wr++;
            if (bus.ow_in_byte == 8'h44) cyc_conv = cyc;
            if (bus.ow_in_byte == 8'hBE) rd_ptr = 0;
        end
        if (!model_init) begin
            bus.ow_out_byte = 8'h00;
            model_init = 1;
        end
        if (ow_act) begin
            ow_t++;
            if (ow_t == 2) bus.ow_busy = 1'b1;
            if (ow_t == 5 && ow_is_rst && pres_en) bus.ow_presense = 1'b1;
            if (ow_t == 10) bus.ow_presense = 1'b0;
            if (ow_t == 22) begin
                bus.ow_busy = 1'b0;
                if (ow_is_rd && rd_ptr < 9) begin
                    bus.ow_out_byte = sp_img[rd_ptr];
                    rd_ptr++;
                end
                ow_act = 0;
            end
        end else begin
            bus.ow_busy     = 1'b0;
            bus.ow_presense = 1'b0;
            if (bus.ow_reset === 1'b1 || bus.ow_read_byte === 1'b1 ||
                (bus.ow_write_byte === 1'b1 && !(ignore_en && bus.ow_in_byte == ignore_cmd))) begin
                ow_act    = 1;
                ow_t      = 0;
                ow_is_rst = (bus.ow_reset === 1'b1);
                ow_is_rd  = (bus.ow_read_byte === 1'b1);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic wait_wr(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_wr >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_rd(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_rd >= target) begin ok = 1; break; end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_present"}, 32'(present), 32'd0);
        check({tag, "_temp"},    32'(temp), 32'd0);
        check({tag, "_tvalid"},  32'(temp_valid), 32'd0);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_err"},     32'(err), 32'd0);
        check({tag, "_strobes"}, {29'd0, bus.ow_reset, bus.ow_write_byte, bus.ow_read_byte}, 32'd0);
        check({tag, "_inbyte"},  32'(bus.ow_in_byte), 32'd0);
    endtask

    task automatic run_nominal(input string tag);
        bit ok;
        int b_wr, b_rd, b_rst, b_done, b_tv;
        b_wr = n_wr; b_rd = n_rd; b_rst = n_rst; b_done = n_done; b_tv = n_tv;
        pulse_start();
        wait_done(3000, ok);
        check({tag, "_finished"}, 32'(ok), 32'd1);
        check({tag, "_err"},      32'(err), 32'd0);
        check({tag, "_temp"},     32'(temp), 32'h0550);
        check({tag, "_tvalid"},   32'(temp_valid), 32'd1);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_present"},  32'(present), 32'd1);
        repeat (3) @(posedge clk); #1;
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_n_done"},   32'(n_done - b_done), 32'd1);
        check({tag, "_n_tv"},     32'(n_tv - b_tv), 32'd1);
        check({tag, "_n_wr"},     32'(n_wr - b_wr), 32'd4);
        check({tag, "_wr0"},      32'(wr_log[b_wr]),     32'hCC);
        check({tag, "_wr1"},      32'(wr_log[b_wr + 1]), 32'h44);
        check({tag, "_wr2"},      32'(wr_log[b_wr + 2]), 32'hCC);
        check({tag, "_wr3"},      32'(wr_log[b_wr + 3]), 32'hBE);
        check({tag, "_n_rd"},     32'(n_rd - b_rd), 32'd9);
        check({tag, "_n_rst"},    32'(n_rst - b_rst), 32'd2);
    endtask

    initial begin
        bit ok;
        int b_wr, b_rd, b_rst, b_done, b_tv, strobes;

        start      = 1'b0;
        rst        = 1'b1;
        pres_en    = 1;
        ignore_en  = 0;
        ignore_cmd = 8'h44;
        sp_img = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

        repeat (4) @(posedge clk); #1;
        check_idle_outputs("reset");
        @(negedge clk) rst = 1'b0;

        run_nominal("nominal");

        // Corrupted CRC byte: temp must keep the previous good value.
        sp_img[8] = 8'h1D;
        b_done = n_done; b_tv = n_tv;
        pulse_start();
        wait_done(3000, ok);
        check("crc_finished", 32'(ok), 32'd1);
        check("crc_err",      32'(err), 32'd2);
        check("crc_temp",     32'(temp), 32'h0550);
        check("crc_tvalid",   32'(temp_valid), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("crc_n_done",   32'(n_done - b_done), 32'd1);
        check("crc_n_tv",     32'(n_tv - b_tv), 32'd0);
        sp_img[8] = 8'h1C;

        // No device on the bus.
        pres_en = 0;
        b_wr = n_wr; b_rd = n_rd; b_rst = n_rst; b_done = n_done;
        pulse_start();
        check("nopres_err_cleared", 32'(err), 32'd0);
        check("nopres_busy",        32'(busy), 32'd1);
        wait_done(500, ok);
        check("nopres_finished", 32'(ok), 32'd1);
        check("nopres_err",      32'(err), 32'd1);
        check("nopres_present",  32'(present), 32'd0);
        repeat (20) @(posedge clk); #1;
        check("nopres_err_held", 32'(err), 32'd1);
        check("nopres_n_wr",     32'(n_wr - b_wr), 32'd0);
        check("nopres_n_rd",     32'(n_rd - b_rd), 32'd0);
        check("nopres_n_rst",    32'(n_rst - b_rst), 32'd1);
        check("nopres_n_done",   32'(n_done - b_done), 32'd1);
        pres_en = 1;

        // Responder ignores Convert T.
        ignore_en = 1;
        b_wr = n_wr;
        pulse_start();
        check("to_err_cleared", 32'(err), 32'd0);
        wait_done(1000, ok);
        check("to_finished", 32'(ok), 32'd1);
        check("to_err",      32'(err), 32'd3);
        check("to_busy",     32'(busy), 32'd0);
        strobes = n_wr + n_rd + n_rst;
        repeat (40) @(posedge clk); #1;
        check("to_latency",  32'(cyc_done - cyc_conv), 32'(ACK_TO));
        check("to_n_wr",     32'(n_wr - b_wr), 32'd2);
        check("to_quiet",    32'(n_wr + n_rd + n_rst), 32'(strobes));
        ignore_en = 0;

        // Reset while waiting for the conversion.
        run_nominal("prime");
        b_wr = n_wr;
        pulse_start();
        wait_wr(b_wr + 2, 1000, ok);
        check("midrst_reached_conv", 32'(ok), 32'd1);
        while (cyc < cyc_conv + 24) begin @(posedge clk); #1; end
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        strobes = n_wr + n_rd + n_rst;
        repeat (40) @(posedge clk); #1;
        check("midrst_quiet", 32'(n_wr + n_rd + n_rst), 32'(strobes));

        // start together with rst: rst wins.
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        check("rst_start_busy", 32'(busy), 32'd0);

        run_nominal("after_rst");

        // Extra start during the fifth read must be ignored.
        b_rd = n_rd; b_done = n_done; b_tv = n_tv;
        pulse_start();
        wait_rd(b_rd + 5, 1000, ok);
        check("dbl_reached_rd4", 32'(ok), 32'd1);
        pulse_start();
        wait_done(3000, ok);
        check("dbl_finished", 32'(ok), 32'd1);
        check("dbl_err",      32'(err), 32'd0);
        check("dbl_temp",     32'(temp), 32'h0550);
        strobes = n_wr + n_rd + n_rst;
        repeat (200) @(posedge clk); #1;
        check("dbl_busy",     32'(busy), 32'd0);
        check("dbl_n_done",   32'(n_done - b_done), 32'd1);
        check("dbl_n_tv",     32'(n_tv - b_tv), 32'd1);
        check("dbl_quiet",    32'(n_wr + n_rd + n_rst), 32'(strobes));
        check("strobe_exclusive", 32'(n_multi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
